// File: rtl/gb_gfx_pkg.sv
// Shared types and defaults for the bitmap graphics write path.
// Holds the default raster size, the shade type and the sequencer state encoding.
package gb_gfx_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;

  typedef logic [1:0] shade_t;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    SWAP
  } fws_state_t;

  // True when (x, y) lies inside the drawable area.
  function automatic logic in_frame(input logic [7:0] x, input logic [7:0] y,
                                    input int h_res, input int v_res);
    return (32'(x) < 32'(h_res)) && (32'(y) < 32'(v_res));
  endfunction

endpackage

// File: rtl/bitmap_raster_counter.sv
// Raster-order x/y address generator used by the clear engine.
// start rewinds to (0,0); step advances x, wrapping into the next row at H_RES-1.
module bitmap_raster_counter #(
  parameter int H_RES = 160,
  parameter int V_RES = 120
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       step,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last
);

  logic x_at_end;
  logic y_at_end;

  assign x_at_end = (x == 8'(H_RES - 1));
  assign y_at_end = (y == 8'(V_RES - 1));
  assign last     = x_at_end && y_at_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= 8'd0;
      y <= 8'd0;
    end else if (start) begin
      x <= 8'd0;
      y <= 8'd0;
    end else if (step) begin
      if (x_at_end) begin
        x <= 8'd0;
        y <= y_at_end ? 8'd0 : y + 8'd1;
      end else begin
        x <= x + 8'd1;
      end
    end
  end

endmodule

// File: rtl/frame_write_sequencer.sv
// Write-port sequencer for the double-buffered bitmap: streams PPU pixels, runs the
// clear engine, and handshakes buffer swaps with the display back end.
module frame_write_sequencer
  import gb_gfx_pkg::*;
#(
  parameter int          H_RES        = H_RES_DEF,
  parameter int          V_RES        = V_RES_DEF,
  parameter shade_t      CLEAR_COLOR  = 2'b00,
  parameter bit          AUTO_CLEAR   = 1'b1,
  parameter int unsigned SWAP_TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [7:0]  pix_x,
  input  logic [7:0]  pix_y,
  input  logic [1:0]  pix_color,
  input  logic        frame_done,
  input  logic        clear_req,
  output logic [7:0]  bm_x,
  output logic [7:0]  bm_y,
  output logic [1:0]  bm_color,
  output logic        bm_wr_en,
  output logic        bm_swap,
  input  logic        bm_swapped,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        swap_err
);

  logic        rst_meta;
  logic        rst_int_n;
  fws_state_t  state;
  fws_state_t  next_state;
  logic        clear_pend;
  logic        done_pend;
  logic [31:0] timer;
  logic        ras_start;
  logic        ras_step;
  logic        ras_last;
  logic [7:0]  ras_x;
  logic [7:0]  ras_y;
  logic        pix_accept;
  logic        swap_ack;
  logic        swap_timeout;

  // Reset asserts immediately but releases two clocks later, in step with clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta  <= 1'b0;
      rst_int_n <= 1'b0;
    end else begin
      rst_meta  <= 1'b1;
      rst_int_n <= rst_meta;
    end
  end

  bitmap_raster_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) u_raster (
    .clk    (clk),
    .reset_n(rst_int_n),
    .start  (ras_start),
    .step   (ras_step),
    .x      (ras_x),
    .y      (ras_y),
    .last   (ras_last)
  );

  assign pix_ready    = rst_int_n && (state == IDLE) && !clear_pend && !done_pend;
  assign busy         = rst_int_n && ((state != IDLE) || clear_pend || done_pend);
  assign pix_accept   = pix_valid && pix_ready;
  assign swap_ack     = (state == SWAP) && bm_swapped;
  assign swap_timeout = (state == SWAP) && !bm_swapped && (SWAP_TIMEOUT != 0) &&
                        (timer == 32'(SWAP_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    ras_step   = 1'b0;
    ras_start  = 1'b0;
    case (state)
      IDLE: begin
        if (clear_pend) begin
          next_state = CLEAR;
        end else if (done_pend) begin
          next_state = SWAP;
        end
      end
      CLEAR: begin
        ras_step = 1'b1;
        if (ras_last) begin
          next_state = IDLE;
        end
      end
      SWAP: begin
        if (swap_ack) begin
          next_state = AUTO_CLEAR ? CLEAR : IDLE;
        end else if (swap_timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
    ras_start = (next_state == CLEAR) && (state != CLEAR);
  end

  // A pulse arriving in the same cycle a request is serviced keeps the flag set.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      clear_pend <= 1'b0;
      done_pend  <= 1'b0;
      timer      <= 32'd0;
    end else begin
      if (clear_req) begin
        clear_pend <= 1'b1;
      end else if ((state == IDLE) && clear_pend) begin
        clear_pend <= 1'b0;
      end
      if (frame_done) begin
        done_pend <= 1'b1;
      end else if (swap_ack || swap_timeout) begin
        done_pend <= 1'b0;
      end
      timer <= (state == SWAP) ? timer + 32'd1 : 32'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      bm_x        <= 8'd0;
      bm_y        <= 8'd0;
      bm_color    <= 2'b00;
      bm_wr_en    <= 1'b0;
      bm_swap     <= 1'b0;
      frame_count <= 16'd0;
      swap_err    <= 1'b0;
    end else begin
      bm_wr_en <= 1'b0;
      if (pix_accept) begin
        bm_x     <= pix_x;
        bm_y     <= pix_y;
        bm_color <= pix_color;
        bm_wr_en <= in_frame(pix_x, pix_y, H_RES, V_RES);
      end else if (state == CLEAR) begin
        bm_x     <= ras_x;
        bm_y     <= ras_y;
        bm_color <= CLEAR_COLOR;
        bm_wr_en <= 1'b1;
      end
      // bm_swap tracks the SWAP state exactly, so it drops on the ack or timeout edge.
      if ((state == IDLE) && (next_state == SWAP)) begin
        bm_swap <= 1'b1;
      end else if (swap_ack || swap_timeout) begin
        bm_swap <= 1'b0;
      end
      if (swap_ack) begin
        frame_count <= frame_count + 16'd1;
      end
      if (swap_timeout) begin
        swap_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_write_sequencer.sv
// Scoreboard bench for frame_write_sequencer: stimulus pushes expected writes,
// a negedge monitor pops and compares every bm_wr_en beat.
module tb_frame_write_sequencer;

  localparam int H = 160;
  localparam int V = 120;
  localparam int TIMEOUT = 100;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [1:0] c;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_x = 8'd0;
  logic [7:0]  pix_y = 8'd0;
  logic [1:0]  pix_color = 2'd0;
  logic        frame_done = 1'b0;
  logic        clear_req = 1'b0;
  logic [7:0]  bm_x;
  logic [7:0]  bm_y;
  logic [1:0]  bm_color;
  logic        bm_wr_en;
  logic        bm_swap;
  logic        bm_swapped = 1'b0;
  logic        busy;
  logic [15:0] frame_count;
  logic        swap_err;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  wr_count = 0;

  frame_write_sequencer #(
    .H_RES(H),
    .V_RES(V),
    .CLEAR_COLOR(2'b00),
    .AUTO_CLEAR(1'b1),
    .SWAP_TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color),
    .frame_done(frame_done), .clear_req(clear_req),
    .bm_x(bm_x), .bm_y(bm_y), .bm_color(bm_color), .bm_wr_en(bm_wr_en),
    .bm_swap(bm_swap), .bm_swapped(bm_swapped),
    .busy(busy), .frame_count(frame_count), .swap_err(swap_err)
  );

  always #5 clk = ~clk;

  // Monitor: every write beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bm_swap) begin
      checks++;
      if (bm_wr_en) begin
        errors++;
        $display("[TB] FAIL wr_during_swap actual=1 expected=0");
      end
    end
    if (bm_wr_en) begin
      wr_t exp_w;
      wr_count++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write actual=(%0d,%0d,%0d) expected=none", bm_x, bm_y, bm_color);
      end else begin
        exp_w = sb.pop_front();
        if ({bm_x, bm_y, bm_color} !== exp_w) begin
          errors++;
          $display("[TB] FAIL write actual=(%0d,%0d,%0d) expected=(%0d,%0d,%0d)",
                   bm_x, bm_y, bm_color, exp_w.x, exp_w.y, exp_w.c);
        end
      end
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp_v);
    end
  endtask

  task automatic push_clear();
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++)
        sb.push_back({8'(x), 8'(y), 2'b00});
  endtask

  task automatic send_pixel(input int x, input int y, input int c, input logic with_done);
    @(negedge clk);
    check_output("pix_ready_before_send", 32'(pix_ready), 32'd1);
    pix_valid  = 1'b1;
    pix_x      = 8'(x);
    pix_y      = 8'(y);
    pix_color  = 2'(c);
    frame_done = with_done;
    if (x < H && y < V) sb.push_back({8'(x), 8'(y), 2'(c)});
    @(negedge clk);
    pix_valid  = 1'b0;
    frame_done = 1'b0;
  endtask

  task automatic wait_drained(input int limit, input string name);
    int n = 0;
    #1;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic wait_swap_rise(input string name);
    int n = 0;
    while (!bm_swap && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(bm_swap), 32'd1);
  endtask

  task automatic pulse_frame_done();
    @(negedge clk);
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check_output(name, {pix_ready, bm_x, bm_y, bm_color, bm_wr_en, bm_swap, busy, swap_err, 9'd0}, 32'd0);
    check_output({name, "_count"}, 32'(frame_count), 32'd0);
  endtask

  task automatic apply_stimulus();
    int hi;
    int base;
    int n;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset_outputs");
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("ready_after_reset", 32'(pix_ready), 32'd1);

    // Pixel stream, including one off-screen pixel that must not be written.
    send_pixel(0, 0, 3, 1'b0);
    send_pixel(159, 119, 1, 1'b0);
    send_pixel(160, 5, 2, 1'b0);
    repeat (2) @(negedge clk);
    check_output("pixel_writes", 32'(wr_count), 32'd2);
    wait_drained(5, "pixel_drain");

    // Explicit full clear.
    @(negedge clk);
    clear_req = 1'b1;
    push_clear();
    @(negedge clk);
    clear_req = 1'b0;
    check_output("clear_busy_start", 32'(busy), 32'd1);
    check_output("clear_not_ready", 32'(pix_ready), 32'd0);
    repeat (10000) @(negedge clk);
    check_output("clear_busy_mid", 32'(busy), 32'd1);
    wait_drained(9300, "clear_drain");
    @(negedge clk);
    check_output("clear_idle_busy", 32'(busy), 32'd0);
    check_output("clear_idle_ready", 32'(pix_ready), 32'd1);

    // Swap acked after 50 cycles of request, followed by the automatic clear.
    check_output("count_before_swap", 32'(frame_count), 32'd0);
    pulse_frame_done();
    wait_swap_rise("swap3_rise");
    hi = 1;
    while (hi < 50 && bm_swap) begin
      @(negedge clk);
      if (bm_swap) hi++;
    end
    check_output("swap3_high_cycles", 32'(hi), 32'd50);
    check_output("swap3_not_ready", 32'(pix_ready), 32'd0);
    bm_swapped = 1'b1;
    push_clear();
    @(negedge clk);
    bm_swapped = 1'b0;
    check_output("swap3_dropped", 32'(bm_swap), 32'd0);
    check_output("swap3_count", 32'(frame_count), 32'd1);
    check_output("swap3_auto_clear_busy", 32'(busy), 32'd1);
    wait_drained(19300, "auto_clear3_drain");

    // Ack held for 10 cycles must count once.
    pulse_frame_done();
    wait_swap_rise("swap4_rise");
    bm_swapped = 1'b1;
    push_clear();
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bm_swap) hi++;
    end
    bm_swapped = 1'b0;
    check_output("swap4_stays_low", 32'(hi), 32'd0);
    check_output("swap4_count", 32'(frame_count), 32'd2);
    wait_drained(19300, "auto_clear4_drain");

    // No ack: timeout after TIMEOUT cycles, sticky error, pixels resume.
    @(negedge clk);
    pulse_frame_done();
    wait_swap_rise("swap5_rise");
    hi = 1;
    n = 0;
    while (bm_swap && n < 300) begin
      @(negedge clk);
      if (bm_swap) hi++;
      n++;
    end
    check_output("timeout_high_cycles", 32'(hi), 32'(TIMEOUT));
    check_output("timeout_err", 32'(swap_err), 32'd1);
    check_output("timeout_count", 32'(frame_count), 32'd2);
    check_output("timeout_ready", 32'(pix_ready), 32'd1);
    send_pixel(10, 20, 2, 1'b0);
    wait_drained(5, "post_timeout_pixel");
    check_output("err_sticky", 32'(swap_err), 32'd1);

    // Pixel and frame_done together: pixel written before the swap starts.
    send_pixel(5, 6, 1, 1'b1);
    wait_swap_rise("combo_swap_rise");
    check_output("combo_pixel_first", 32'(sb.size()), 32'd0);
    n = 0;
    while (bm_swap && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output("combo_swap_end", 32'(bm_swap), 32'd0);
    check_output("combo_count", 32'(frame_count), 32'd2);

    // Reset in the middle of a clear.
    @(negedge clk);
    clear_req = 1'b1;
    push_clear();
    @(negedge clk);
    clear_req = 1'b0;
    base = wr_count;
    n = 0;
    while (wr_count < base + 500 && n < 1000) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("mid_clear_writes", 32'(wr_count - base), 32'd500);
    #2 reset_n = 1'b0;
    #1;
    check_all_zero("async_reset_outputs");
    sb.delete();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check_output("post_reset_ready", 32'(pix_ready), 32'd1);
    check_output("post_reset_busy", 32'(busy), 32'd0);
    check_output("post_reset_count", 32'(frame_count), 32'd0);
    check_output("post_reset_err", 32'(swap_err), 32'd0);
    base = wr_count;
    repeat (20) @(negedge clk);
    check_output("no_writes_after_reset", 32'(wr_count - base), 32'd0);
  endtask

  initial begin
    apply_stimulus();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
